// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with a one-entry skid buffer.
// in_ready depends only on registered state, so no out_ready path reaches ID.
module idex_pipe_reg #(
    parameter int unsigned CTRL_W = 17,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] opa_in,
    input  logic [DATA_W-1:0] opb_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [REG_W-1:0]  rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] opa_out,
    output logic [DATA_W-1:0] opb_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [REG_W-1:0]  rd_out,
    output logic [2:0]        alu_op,
    output logic [2:0]        src_op,
    output logic              load_instr,
    output logic              rf_enable,
    output logic              branch_instr,
    output logic [15:0]       stall_cnt
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rd;
    } entry_t;

    entry_t main_q;
    entry_t skid_q;
    entry_t in_e;
    logic   main_valid;
    logic   skid_valid;
    logic   accept;
    logic   main_free;

    assign in_e      = '{ctrl: ctrl_in, opa: opa_in, opb: opb_in,
                         imm: imm_in, rd: rd_in};
    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready && !flush;
    assign main_free = !main_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= accept;
                if (accept)
                    skid_q <= in_e;
            end else begin
                main_valid <= accept;
                if (accept)
                    main_q <= in_e;
            end
        end else if (accept) begin
            skid_q     <= in_e;
            skid_valid <= 1'b1;
        end
    end

    // Flush cycles still count: the stall is visible to EX regardless.
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (main_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign out_valid    = main_valid;
    assign ctrl_out     = main_q.ctrl;
    assign opa_out      = main_q.opa;
    assign opb_out      = main_q.opb;
    assign imm_out      = main_q.imm;
    assign rd_out       = main_q.rd;
    assign alu_op       = main_valid ? main_q.ctrl[13:11] : 3'b000;
    assign src_op       = main_valid ? main_q.ctrl[16:14] : 3'b000;
    assign load_instr   = main_valid && main_q.ctrl[10];
    assign rf_enable    = main_valid && main_q.ctrl[9];
    assign branch_instr = main_valid && main_q.ctrl[8];

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Bench for idex_pipe_reg: two-deep FIFO model plus directed literal checks.
module tb_idex_pipe_reg;
    localparam int CW = 20;
    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] ctrl_in, ctrl_out;
    logic [DW-1:0] opa_in, opb_in, imm_in, opa_out, opb_out, imm_out;
    logic [RW-1:0] rd_in, rd_out;
    logic [2:0]    alu_op, src_op;
    logic          load_instr, rf_enable, branch_instr;
    logic [15:0]   stall_cnt;

    idex_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .REG_W(RW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_in(ctrl_in), .opa_in(opa_in), .opb_in(opb_in),
        .imm_in(imm_in), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_out(ctrl_out), .opa_out(opa_out), .opb_out(opb_out),
        .imm_out(imm_out), .rd_out(rd_out),
        .alu_op(alu_op), .src_op(src_op), .load_instr(load_instr),
        .rf_enable(rf_enable), .branch_instr(branch_instr),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] opa;
        logic [DW-1:0] opb;
        logic [DW-1:0] imm;
        logic [RW-1:0] rd;
    } ent_t;

    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 0;
    ent_t q[$];
    ent_t shown;
    int   m_stall;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: the stage behaves as a two-entry FIFO viewed from outside.
    always @(posedge clk) begin
        ent_t e;
        bit   acc;
        if (reset) begin
            q.delete();
            shown   = '0;
            m_stall = 0;
        end else begin
            if (q.size() > 0 && !out_ready && m_stall < 65535)
                m_stall++;
            acc = in_valid && q.size() < 2 && !flush;
            e   = '{ctrl_in, opa_in, opb_in, imm_in, rd_in};
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && out_ready)
                    void'(q.pop_front());
                if (acc)
                    q.push_back(e);
            end
            if (q.size() > 0)
                shown = q[0];
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit v;
            v = q.size() > 0;
            check("m_out_valid", 128'(out_valid), 128'(v));
            check("m_in_ready", 128'(in_ready), 128'(q.size() < 2));
            check("m_stall_cnt", 128'(stall_cnt), 128'(m_stall));
            check("m_entry", 128'({ctrl_out, opa_out, opb_out, imm_out, rd_out}),
                  128'(shown));
            check("m_decoded",
                  128'({alu_op, src_op, load_instr, rf_enable, branch_instr}),
                  v ? 128'({shown.ctrl[13:11], shown.ctrl[16:14],
                            shown.ctrl[10], shown.ctrl[9], shown.ctrl[8]})
                    : 128'(0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [RW-1:0] r);
        in_valid = 1'b1;
        ctrl_in  = c;
        opa_in   = a;
        opb_in   = b;
        imm_in   = a + 32'h1000;
        rd_in    = r;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ctrl_in = '0; opa_in = '0; opb_in = '0; imm_in = '0; rd_in = '0;
        cyc(1);
        cmp_en = 1;
        do_reset();
        cyc(1);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_outputs", 128'({ctrl_out, opa_out, opb_out, imm_out, rd_out,
                                   alu_op, src_op, load_instr, rf_enable,
                                   branch_instr}), 128'(0));
        check("rst_stall", 128'(stall_cnt), 128'(0));

        // single transfer
        send(20'h03A00, 32'd5, 32'd7, 5'd3);
        cyc(1);
        in_valid = 1'b0;
        check("st_valid", 128'(out_valid), 128'(1));
        check("st_alu", 128'(alu_op), 128'(3'b111));
        check("st_flags", 128'({load_instr, rf_enable, branch_instr, src_op}),
              128'(6'b010_000));
        check("st_opa", 128'(opa_out), 128'(5));
        cyc(1);
        check("st_bubble", 128'({out_valid, alu_op, rf_enable}), 128'(0));
        check("st_hold", 128'(ctrl_out), 128'(20'h03A00));

        // back-pressure: A in main, B in skid
        out_ready = 1'b0;
        send(20'h01200, 32'd100, 32'd1, 5'd10);
        cyc(1);
        send(20'h04600, 32'd200, 32'd2, 5'd11);
        cyc(1);
        in_valid = 1'b0;
        check("bp_in_ready", 128'(in_ready), 128'(0));
        check("bp_stall1", 128'(stall_cnt), 128'(1));
        cyc(1);
        check("bp_hold_a", 128'(rd_out), 128'(10));
        check("bp_stall2", 128'(stall_cnt), 128'(2));
        out_ready = 1'b1;
        cyc(1);
        check("bp_b_next", 128'({out_valid, rd_out, opa_out}),
              128'({1'b1, 5'd11, 32'd200}));
        check("bp_ready_back", 128'(in_ready), 128'(1));
        cyc(1);
        check("bp_drained", 128'(out_valid), 128'(0));

        // flush with both entries held and an input offered
        out_ready = 1'b0;
        send(20'h0FF00, 32'd300, 32'd3, 5'd12);
        cyc(1);
        send(20'h0FF00, 32'd400, 32'd4, 5'd13);
        cyc(1);
        send(20'h0FF00, 32'd500, 32'd5, 5'd14);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("fl_valid", 128'(out_valid), 128'(0));
        check("fl_in_ready", 128'(in_ready), 128'(1));
        check("fl_decoded", 128'({alu_op, src_op, load_instr, rf_enable,
                                  branch_instr}), 128'(0));
        check("fl_stall", 128'(stall_cnt), 128'(4));
        cyc(3);
        check("fl_no_entry", 128'(out_valid), 128'(0));

        // reset mid-stall with both entries valid
        out_ready = 1'b0;
        send(20'h03A00, 32'd600, 32'd6, 5'd15);
        cyc(1);
        send(20'h03A00, 32'd700, 32'd7, 5'd16);
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("rs_cleared", 128'({out_valid, ctrl_out, opa_out, rd_out,
                                  stall_cnt}), 128'(0));
        check("rs_in_ready", 128'(in_ready), 128'(1));
        cyc(3);
        check("rs_no_entry", 128'(out_valid), 128'(0));

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 20) == 0;
            ctrl_in   = CW'($urandom);
            opa_in    = n;
            opb_in    = $urandom;
            imm_in    = $urandom;
            rd_in     = RW'(n);
            cyc(1);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc(3);

        // stall counter saturation
        do_reset();
        out_ready = 1'b0;
        send(20'h03A00, 32'd9, 32'd9, 5'd9);
        cyc(1);
        in_valid = 1'b0;
        cyc(65540);
        check("sat_ffff", 128'(stall_cnt), 128'(16'hFFFF));
        cyc(5);
        check("sat_stays", 128'(stall_cnt), 128'(16'hFFFF));
        check("sat_held", 128'({out_valid, rd_out}), 128'({1'b1, 5'd9}));

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/idex_pipe_reg.md
IDEX_PIPE_REG -- requirements
Module: idex_pipe_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 17, control-word width; legal values are CTRL_W >= 17.
REQ-002 SHALL have parameter DATA_W, default 32, operand and immediate width.
REQ-003 SHALL have parameter REG_W, default 5, destination register index width.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  squash all held and incoming entries.
REQ-007 SHALL have port in_valid  input  1  upstream (ID) entry present.
REQ-008 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-009 SHALL have port ctrl_in  input  CTRL_W  control word.
REQ-010 SHALL have port opa_in, opb_in, imm_in  input  DATA_W each  operand A, operand B and immediate.
REQ-011 SHALL have port rd_in  input  REG_W  destination register.
REQ-012 SHALL have port out_valid  output  1  EX entry present.
REQ-013 SHALL have port out_ready  input  1  downstream (EX) consumes the entry.
REQ-014 SHALL have port ctrl_out, opa_out, opb_out, imm_out, rd_out  output  same widths as the inputs  held entry.
REQ-015 SHALL have port alu_op  output  3  ctrl_out[13:11].
REQ-016 SHALL have port src_op  output  3  ctrl_out[16:14].
REQ-017 SHALL have port load_instr  output  1  ctrl_out[10].
REQ-018 SHALL have port rf_enable  output  1  ctrl_out[9].
REQ-019 SHALL have port branch_instr  output  1  ctrl_out[8].
REQ-020 SHALL have port stall_cnt  output  16  count of back-pressured cycles.

Function
REQ-021 SHALL hold two entries: a main register, which drives the outputs, and a skid register; each entry has its own valid bit.
REQ-022 SHALL drive in_ready = !skid_valid; this is a registered-state function only, with no combinational path from out_ready.
REQ-023 SHALL accept an entry when in_valid && in_ready && !flush.
REQ-024 SHALL treat the main register as free when !main_valid || out_ready.
REQ-025 If main is free and skid is valid, SHALL move skid into main and clear skid_valid; an entry accepted in the same cycle SHALL then go into skid.
REQ-026 If main is free and skid is empty, SHALL load an accepted entry into main, or clear main_valid if none is accepted.
REQ-027 If main is not free, SHALL keep main unchanged and load an accepted entry into skid.
REQ-028 SHALL have latency of 1 cycle from acceptance to out_valid when main is free.
REQ-029 SHALL deliver entries in order, with no loss and no duplication.
REQ-030 SHALL drive out_valid = main_valid.
REQ-031 SHALL force alu_op, src_op, load_instr, rf_enable and branch_instr to 0 whenever out_valid = 0, so that bubbles never write the register file.
REQ-032 SHALL leave ctrl_out and data outputs holding their last value when out_valid = 0.
REQ-033 flush SHALL have highest priority after reset: on the next edge main_valid = skid_valid = 0.
REQ-034 During flush, the input entry SHALL be dropped even if in_valid && in_ready.
REQ-035 During flush, data registers SHALL NOT be required to change.
REQ-036 stall_cnt SHALL increment by 1 on every edge where out_valid && !out_ready, and SHALL saturate at 16'hFFFF.
REQ-037 flush SHALL NOT clear stall_cnt.
REQ-038 A cycle with both flush and a stall condition SHALL still count.
REQ-039 When skid is full, in_ready SHALL be 0.
REQ-040 Acceptance and drain of skid SHALL be allowed in the same cycle.

Reset
REQ-041 On reset = 1 at an edge, main_valid, skid_valid and stall_cnt SHALL be cleared to 0, overriding flush and handshakes; in_ready SHALL be 1 in the following cycle.
REQ-042 On reset, ctrl_out, opa_out, opb_out, imm_out and rd_out SHALL be cleared to 0; decoded outputs are therefore 0.
REQ-043 Reset asserted mid-stall with both entries valid SHALL discard both entries; no entry appears after reset deasserts.

Verification
REQ-044 Reset then idle -> out_valid=0, in_ready=1, all outputs 0, stall_cnt=0.
REQ-045 Single transfer: ctrl_in=17'h0_3A00, opa=5, opb=7, rd=3, out_ready=1 -> next cycle out_valid=1, alu_op=3'b111, load_instr=0, rf_enable=1, branch_instr=0, src_op=0, opa_out=5.
REQ-046 Back-pressure: out_ready=0 while A then B are sent -> A held in main, B in skid, in_ready=0, stall_cnt increments each cycle; raise out_ready -> A then B emitted on consecutive cycles, in order.
REQ-047 Flush with both entries valid and in_valid=1 -> next cycle out_valid=0, in_ready=1, decoded outputs 0, the input entry never appears.
REQ-048 Saturation: hold out_valid=1 with out_ready=0 for 65540 cycles -> stall_cnt=16'hFFFF and stays there.
REQ-049 Random in_valid/out_ready/flush against a scoreboard model with CTRL_W=20 -> order preserved, no loss or duplication except flushed entries.
